// File: rtl/beat_pkg.sv
// Shared types and default sizing for the beat conditioner and the heartbeat monitor FSM.
package beat_pkg;

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } beat_state_t;

  localparam int unsigned DEB_CYCLES_DEF = 4;
  localparam int unsigned NBITS_INT_DEF  = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, synchronous active-high reset to 0.
module sync_2ff (
  input  logic clk_2,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_2) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/beat_conditioner.sv
// Synchronises and debounces the raw beat switch, emitting one pulse per accepted rising edge.
// Define BEAT_INTERVAL_EN to also measure the beat-to-beat interval in clock cycles.
module beat_conditioner
  import beat_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned NBITS_INT  = NBITS_INT_DEF
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic                 beat_raw,
  output logic                 beat_pulse,
  output logic                 beat_level,
  output logic                 glitch,
  output logic [NBITS_INT-1:0] interval,
  output logic                 interval_valid
);

  localparam int unsigned      CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  beat_state_t      state, state_nxt;
  logic [CNT_W-1:0] deb_cnt, deb_cnt_nxt;
  logic             beat_s;
  logic             pulse_nxt, glitch_nxt, level_nxt;

  sync_2ff u_sync (
    .clk_2 (clk_2),
    .reset (reset),
    .d     (beat_raw),
    .q     (beat_s)
  );

  // State, counter and registered outputs
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state      <= LOW;
      deb_cnt    <= '0;
      beat_pulse <= 1'b0;
      glitch     <= 1'b0;
      beat_level <= 1'b0;
    end else begin
      state      <= state_nxt;
      deb_cnt    <= deb_cnt_nxt;
      beat_pulse <= pulse_nxt;
      glitch     <= glitch_nxt;
      beat_level <= level_nxt;
    end
  end

  // Next state: a level is accepted only after holding for DEB_CYCLES checks in *_CHK
  always_comb begin
    state_nxt   = state;
    deb_cnt_nxt = deb_cnt;
    pulse_nxt   = 1'b0;
    glitch_nxt  = 1'b0;
    unique case (state)
      LOW: begin
        if (beat_s) begin
          state_nxt   = RISE_CHK;
          deb_cnt_nxt = '0;
        end
      end
      RISE_CHK: begin
        if (!beat_s) begin
          state_nxt   = LOW;
          deb_cnt_nxt = '0;
          glitch_nxt  = 1'b1;
        end else if (deb_cnt == CNT_LAST) begin
          state_nxt   = HIGH;
          deb_cnt_nxt = '0;
          pulse_nxt   = 1'b1;
        end else begin
          deb_cnt_nxt = deb_cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!beat_s) begin
          state_nxt   = FALL_CHK;
          deb_cnt_nxt = '0;
        end
      end
      FALL_CHK: begin
        if (beat_s) begin
          state_nxt   = HIGH;
          deb_cnt_nxt = '0;
          glitch_nxt  = 1'b1;
        end else if (deb_cnt == CNT_LAST) begin
          state_nxt   = LOW;
          deb_cnt_nxt = '0;
        end else begin
          deb_cnt_nxt = deb_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt   = LOW;
        deb_cnt_nxt = '0;
      end
    endcase
    level_nxt = (state_nxt == HIGH) || (state_nxt == FALL_CHK);
  end

`ifdef BEAT_INTERVAL_EN
  localparam logic [NBITS_INT-1:0] INT_MAX = '1;

  logic [NBITS_INT-1:0] int_cnt;
  logic                 first_seen;

  // Interval counter restarts at 1 on each pulse; first pulse after reset only arms it
  always_ff @(posedge clk_2) begin
    if (reset) begin
      int_cnt        <= '0;
      first_seen     <= 1'b0;
      interval       <= '0;
      interval_valid <= 1'b0;
    end else begin
      interval_valid <= 1'b0;
      if (pulse_nxt) begin
        int_cnt    <= NBITS_INT'(1);
        first_seen <= 1'b1;
        if (first_seen) begin
          interval       <= int_cnt;
          interval_valid <= 1'b1;
        end
      end else if (int_cnt != INT_MAX) begin
        int_cnt <= int_cnt + NBITS_INT'(1);
      end
    end
  end
`else
  assign interval       = '0;
  assign interval_valid = 1'b0;
`endif

endmodule

// File: tb/tb_beat_conditioner.sv
// Randomised and directed bench for beat_conditioner against a run-length reference model.
module tb_beat_conditioner;
  import beat_pkg::*;

  localparam int DEB     = 4;
  localparam int NB      = 8;
  localparam int INT_SAT = (1 << NB) - 1;

  logic          clk_2 = 1'b0;
  logic          reset = 1'b1;
  logic          beat_raw = 1'b0;
  logic          beat_pulse, beat_level, glitch, interval_valid;
  logic [NB-1:0] interval;

  beat_conditioner #(.DEB_CYCLES(DEB), .NBITS_INT(NB)) dut (
    .clk_2          (clk_2),
    .reset          (reset),
    .beat_raw       (beat_raw),
    .beat_pulse     (beat_pulse),
    .beat_level     (beat_level),
    .glitch         (glitch),
    .interval       (interval),
    .interval_valid (interval_valid)
  );

  always #5 clk_2 = ~clk_2;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the FSM sees raw two edges late; a level flips once the
  // opposite value has been seen on DEB+1 consecutive edges, shorter runs are glitches.
  int   m_edge = 0;
  logic h1 = 1'b0, h2 = 1'b0;
  logic m_level = 1'b0, m_pulse = 1'b0, m_glitch = 1'b0, m_valid = 1'b0;
  int   m_run = 0, m_interval = 0, m_prev = 0;
  bit   m_have_prev = 1'b0;

  task automatic model_edge(input logic raw, input logic rst);
    logic s;
    m_edge++;
    if (rst) begin
      h1 = 1'b0; h2 = 1'b0;
      m_level = 1'b0; m_run = 0;
      m_pulse = 1'b0; m_glitch = 1'b0;
      m_interval = 0; m_valid = 1'b0; m_have_prev = 1'b0;
    end else begin
      s = h2; h2 = h1; h1 = raw;
      m_pulse = 1'b0; m_glitch = 1'b0; m_valid = 1'b0;
      if (s != m_level) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_level = s;
          m_run   = 0;
          if (s) begin
            m_pulse = 1'b1;
            if (m_have_prev) begin
              m_interval = (m_edge - m_prev > INT_SAT) ? INT_SAT : m_edge - m_prev;
              m_valid    = 1'b1;
            end
            m_prev      = m_edge;
            m_have_prev = 1'b1;
          end
        end
      end else begin
        m_glitch = (m_run > 0);
        m_run    = 0;
      end
    end
  endtask

  int pulse_cnt = 0, glitch_cnt = 0, valid_cnt = 0, last_pulse_edge = 0;

  task automatic step(input logic raw, input logic rst);
    @(negedge clk_2);
    beat_raw = raw;
    reset    = rst;
    @(posedge clk_2);
    model_edge(raw, rst);
    #1;
    check_eq("pulse", 32'(beat_pulse), 32'(m_pulse));
    check_eq("glitch", 32'(glitch), 32'(m_glitch));
    check_eq("level", 32'(beat_level), 32'(m_level));
    check_eq("excl", 32'(beat_pulse & glitch), 32'(0));
`ifdef BEAT_INTERVAL_EN
    check_eq("interval", 32'(interval), 32'(m_interval));
    check_eq("ivalid", 32'(interval_valid), 32'(m_valid));
`else
    check_eq("interval", 32'(interval), 32'(0));
    check_eq("ivalid", 32'(interval_valid), 32'(0));
`endif
    if (beat_pulse === 1'b1) begin
      pulse_cnt++;
      last_pulse_edge = m_edge;
    end
    if (glitch === 1'b1) glitch_cnt++;
    if (interval_valid === 1'b1) valid_cnt++;
  endtask

  task automatic hold(input logic raw, input int n);
    for (int i = 0; i < n; i++) step(raw, 1'b0);
  endtask

  task automatic clear_counts();
    pulse_cnt = 0; glitch_cnt = 0; valid_cnt = 0; last_pulse_edge = 0;
  endtask

  int k;

  initial begin
    // Reset state
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check_eq("rst_state", 32'(dut.state), 32'(LOW));
    hold(1'b0, 4);

    // 1: clean rising edge held 12 cycles
    clear_counts();
    step(1'b1, 1'b0);
    k = m_edge;
    hold(1'b1, 11);
    check_eq("t1_pulses", 32'(pulse_cnt), 32'(1));
    check_eq("t1_latency", 32'(last_pulse_edge - k), 32'(DEB + 2));
    check_eq("t1_glitches", 32'(glitch_cnt), 32'(0));
    check_eq("t1_level", 32'(beat_level), 32'(1));
    hold(1'b0, 10);

    // 2: two-cycle bounce while low
    clear_counts();
    hold(1'b1, 2);
    hold(1'b0, 10);
    check_eq("t2_pulses", 32'(pulse_cnt), 32'(0));
    check_eq("t2_glitches", 32'(glitch_cnt), 32'(1));
    check_eq("t2_state", 32'(dut.state), 32'(LOW));
    check_eq("t2_level", 32'(beat_level), 32'(0));

    // 3: two-cycle dropout while high
    hold(1'b1, 10);
    clear_counts();
    hold(1'b0, 2);
    hold(1'b1, 10);
    check_eq("t3_pulses", 32'(pulse_cnt), 32'(0));
    check_eq("t3_glitches", 32'(glitch_cnt), 32'(1));
    check_eq("t3_level", 32'(beat_level), 32'(1));
    hold(1'b0, 10);

    // 4: beats 20 edges apart after a fresh reset
    step(1'b0, 1'b1);
    clear_counts();
    for (int b = 0; b < 3; b++) begin
      hold(1'b1, 10);
      hold(1'b0, 10);
    end
    check_eq("t4_pulses", 32'(pulse_cnt), 32'(3));
`ifdef BEAT_INTERVAL_EN
    check_eq("t4_valids", 32'(valid_cnt), 32'(2));
    check_eq("t4_interval", 32'(interval), 32'(20));
`else
    check_eq("t4_valids", 32'(valid_cnt), 32'(0));
`endif

    // 5: beats 300 edges apart saturate the interval
    for (int b = 0; b < 2; b++) begin
      hold(1'b1, 10);
      hold(1'b0, 290);
    end
`ifdef BEAT_INTERVAL_EN
    check_eq("t5_interval", 32'(interval), 32'(INT_SAT));
`else
    check_eq("t5_interval", 32'(interval), 32'(0));
`endif

    // 6: reset during RISE_CHK with deb_cnt=2
    hold(1'b1, 5);
    check_eq("t6_pre_state", 32'(dut.state), 32'(RISE_CHK));
    check_eq("t6_pre_cnt", 32'(dut.deb_cnt), 32'(2));
    step(1'b1, 1'b1);
    check_eq("t6_state", 32'(dut.state), 32'(LOW));
    check_eq("t6_outs", {28'd0, beat_pulse, beat_level, glitch, interval_valid}, 32'(0));
    clear_counts();
    step(1'b1, 1'b0);
    k = m_edge;
    hold(1'b1, 4);
    check_eq("t6_early", 32'(pulse_cnt), 32'(0));
    hold(1'b1, 8);
    check_eq("t6_pulses", 32'(pulse_cnt), 32'(1));
    check_eq("t6_latency", 32'(last_pulse_edge - k), 32'(DEB + 2));

    // Random bursts with occasional resets
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 40) == 0) step(1'(($urandom) & 1), 1'b1);
      hold(1'(($urandom) & 1), int'($urandom_range(1, 9)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
